// File: rtl/sync_arbiter_rr_if.sv
// Request/grant bundle between the requesting agents and the round-robin arbiter.
// The master modport is the requester side. The slave modport is the arbiter side.
interface sync_arbiter_rr_if #(
    parameter int N    = 4,
    parameter int ID_W = 2
);
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            busy;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output busy
    );
endinterface

// File: rtl/sync_arbiter_rr.sv
// N-way round-robin arbiter with a registered one-hot grant.
// A grant is held while its request stays high. Every grant is followed by a
// single turnaround cycle with no grant. The search for the next requester
// starts just below the last one granted, so every requester is eventually served.
// Optional feature: define ARB_MAX_HOLD_EN to force a release after HOLD_MAX
// granted cycles whenever another requester is waiting.
module sync_arbiter_rr #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    sync_arbiter_rr_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [ID_W-1:0] grantId_q, grantId_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            busy_q, busy_d;
    logic [ID_W-1:0] selId;
    logic            selValid;
    logic            holdExpire;

`ifdef ARB_MAX_HOLD_EN
    logic [3:0] holdCnt_q, holdCnt_d;
    logic       otherReq;

    assign otherReq   = |(bus.req & ~grant_q);
    assign holdExpire = (holdCnt_q >= 4'(HOLD_MAX - 1)) && otherReq;

    // The hold counter clears when a grant starts and counts granted cycles, saturating at HOLD_MAX.
    always_comb begin
        holdCnt_d = holdCnt_q;
        if (state_d == GRANT && state_q != GRANT) begin
            holdCnt_d = '0;
        end else if (state_d == GRANT && holdCnt_q < 4'(HOLD_MAX)) begin
            holdCnt_d = holdCnt_q + 4'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdCnt_q <= '0;
        end else begin
            holdCnt_q <= holdCnt_d;
        end
    end
`else
    assign holdExpire = 1'b0;
`endif

    // Descending search with wrap: start at ptr and pick the first active request.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idxW;
        selValid = 1'b0;
        selId    = '0;
        idx      = 0;
        idxW     = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) - k;
            if (idx < 0) begin
                idx = idx + N;
            end
            idxW = ID_W'(idx);
            if (!selValid && bus.req[idxW]) begin
                selValid = 1'b1;
                selId    = idxW;
            end
        end
    end

    // Next state and next registered outputs. Outputs are Moore-style and registered with the state.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        grantId_d = grantId_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        unique case (state_q)
            IDLE, TURN: begin
                if (selValid) begin
                    state_d   = GRANT;
                    grant_d   = N'(1) << selId;
                    grantId_d = selId;
                    busy_d    = 1'b1;
                end else begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    grantId_d = '0;
                    busy_d    = 1'b0;
                end
            end
            GRANT: begin
                if (!bus.req[grantId_q] || holdExpire) begin
                    state_d   = TURN;
                    grant_d   = '0;
                    grantId_d = '0;
                    busy_d    = 1'b0;
                    ptr_d     = (grantId_q == '0) ? ID_W'(N - 1) : grantId_q - 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                grantId_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers. Reset clears everything at once, with no clock edge needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            grantId_q <= '0;
            ptr_q     <= ID_W'(N - 1);
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            grantId_q <= grantId_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grantId_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sync_arbiter_rr.sv
// Testbench for sync_arbiter_rr.
// A behavioural cycle model predicts {busy, grant_id, grant} for each driven request vector.
// The prediction is queued and compared one edge later against the DUT.
module tb_sync_arbiter_rr;

    localparam int N        = 4;
    localparam int ID_W     = 2;
    localparam int HOLD_MAX = 8;

    logic clk;
    logic reset;

    int vecCount;
    int errCount;

    logic [31:0] expQ[$];

    // Behavioural model state: 0 = idle, 1 = granting, 2 = turnaround.
    int mState;
    int mPtr;
    int mG;
    int mHold;

    sync_arbiter_rr_if #(.N(N), .ID_W(ID_W)) bus ();

    sync_arbiter_rr #(.N(N), .ID_W(ID_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] observe();
        return 32'({bus.busy, bus.grant_id, bus.grant});
    endfunction

    task automatic modelReset();
        mState = 0;
        mPtr   = N - 1;
        mG     = 0;
        mHold  = 0;
    endtask

    function automatic logic [31:0] modelOutputs();
        logic [N-1:0]    g;
        logic [ID_W-1:0] id;
        g  = '0;
        id = '0;
        if (mState == 1) begin
            g[mG] = 1'b1;
            id    = ID_W'(mG);
        end
        return 32'({(mState == 1), id, g});
    endfunction

    // Advances the model by one rising edge with request vector r sampled at that edge.
    task automatic modelStep(input logic [N-1:0] r);
        int  pick;
        int  i;
        bit  rel;
        bit  others;
        if (!reset) begin
            modelReset();
            return;
        end
        if (mState == 1) begin
            others = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != mG && r[j]) others = 1'b1;
            end
            rel = !r[mG];
`ifdef ARB_MAX_HOLD_EN
            if (mHold >= HOLD_MAX - 1 && others) rel = 1'b1;
`endif
            if (rel) begin
                mState = 2;
                mPtr   = (mG == 0) ? N - 1 : mG - 1;
            end else begin
                if (mHold < HOLD_MAX) mHold++;
            end
        end else begin
            pick = -1;
            i    = mPtr;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && r[i]) pick = i;
                i = (i == 0) ? N - 1 : i - 1;
            end
            if (pick >= 0) begin
                mState = 1;
                mG     = pick;
                mHold  = 0;
            end else begin
                mState = 0;
            end
        end
    endtask

    // Drive one request vector at the falling edge, queue the prediction, and compare just after the rising edge.
    task automatic applyStimulus(input string tag, input logic [N-1:0] r);
        logic [31:0] exp;
        @(negedge clk);
        bus.req = r;
        modelStep(r);
        expQ.push_back(modelOutputs());
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 32'd1, 32'd0);
        end else begin
            exp = expQ.pop_front();
            checkOutput(tag, observe(), exp);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        vecCount = 0;
        errCount = 0;
        reset    = 1'b0;
        bus.req  = 4'b1111;
        modelReset();

        // Reset held with all requests active: outputs stay clear even with clocks running.
        #1;
        checkOutput("rst_async", observe(), 32'd0);
        applyStimulus("rst_hold", 4'b1111);
        applyStimulus("rst_hold", 4'b1111);

        // Release reset: the first edge grants requester 3.
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("rst_first", 4'b1111);
        checkOutput("rst_first_const", observe(), 32'({1'b1, 2'd3, 4'b1000}));

        // Rotation: each holder drops its bit after two granted cycles.
        applyStimulus("rot", 4'b1111);
        applyStimulus("rot", 4'b0111);
        for (int j = 2; j >= 0; j--) begin
            applyStimulus("rot", 4'b1111);
            applyStimulus("rot", 4'b1111);
            r = 4'b1111;
            r[j] = 1'b0;
            applyStimulus("rot", r);
        end
        applyStimulus("rot_wrap", 4'b1111);
        checkOutput("rot_wrap_const", observe(), 32'({1'b1, 2'd3, 4'b1000}));
        applyStimulus("rot", 4'b0111);
        applyStimulus("rot", 4'b0000);
        applyStimulus("idle", 4'b0000);

        // Pointer: after requester 1 releases, requester 0 is searched before requester 3.
        applyStimulus("ptr", 4'b0010);
        applyStimulus("ptr", 4'b0010);
        applyStimulus("ptr", 4'b0000);
        applyStimulus("ptr_sel", 4'b1011);
        checkOutput("ptr_sel_const", observe(), 32'({1'b1, 2'd0, 4'b0001}));
        applyStimulus("ptr", 4'b0000);
        applyStimulus("idle", 4'b0000);

        // Single requester held for five cycles, then released.
        for (int k = 0; k < 5; k++) applyStimulus("single", 4'b0001);
        applyStimulus("single_rel", 4'b0000);
        applyStimulus("single_idle", 4'b0000);

        // Asynchronous reset in the middle of a grant.
        applyStimulus("mid", 4'b0100);
        applyStimulus("mid", 4'b0100);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_async", observe(), 32'd0);
        modelReset();
        applyStimulus("mid_rst_hold", 4'b0100);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("mid_regrant", 4'b0100);
        checkOutput("mid_regrant_const", observe(), 32'({1'b1, 2'd2, 4'b0100}));
        applyStimulus("mid", 4'b0000);
        applyStimulus("idle", 4'b0000);

        // Two competing requesters held constant, then one requester alone.
        for (int k = 0; k < 30; k++) applyStimulus("hold_pair", 4'b1100);
        applyStimulus("hold_pair", 4'b0000);
        applyStimulus("hold_pair", 4'b0000);
        for (int k = 0; k < 20; k++) applyStimulus("hold_solo", 4'b1000);
        applyStimulus("hold_solo", 4'b1100);
        applyStimulus("hold_solo", 4'b1100);

        // Random requests, with an inverted glitch between edges that must be ignored.
        for (int k = 0; k < 200; k++) begin
            r = 4'($urandom_range(0, 15));
            applyStimulus("rand", r);
            bus.req = ~r;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/sync_arbiter_rr.md
Name: sync_arbiter_rr

Overview:
- Synchronous N-way round-robin arbiter for a shared resource.
- Moore FSM with registered one-hot grant. Tie-break starts at the MSB after reset, then rotates so no requester starves.
- A grant is held for as long as its request stays high, followed by one mandatory turnaround cycle before the next grant.
- Sits between requesting agents and the shared bus/resource. It is the fair-arbitration successor to the fixed-priority 1-hot arbiter.

Parameters:
- N, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must satisfy 2^ID_W >= N.
- HOLD_MAX, 8, maximum consecutive granted cycles when ARB_MAX_HOLD_EN is defined (1..15).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- req  input  N  active-high requests, bit i = requester i.
- grant  output  N  registered one-hot (or zero) grant, bit i = requester i.
- grant_id  output  ID_W  binary index of granted requester; 0 when grant==0.
- busy  output  1  high while grant != 0.

Behaviour:
- Reset (reset==0, asynchronous, no clock needed):
  - grant=0, grant_id=0, busy=0.
  - state=IDLE, ptr=N-1, hold_cnt=0.
- States:
  - IDLE: no grant.
  - GRANT: grant[g]=1.
  - TURN: one-cycle gap, grant=0.
- Arbitration (combinational, from req and ptr): search indices ptr, ptr-1, ..., 0, N-1, ... (descending with wrap). Select the first i with req[i]=1.
- IDLE:
  - If any req at a rising edge, go to GRANT with g=selected. grant is visible after that edge (1-cycle latency).
  - Otherwise stay in IDLE.
- GRANT:
  - While req[g]=1 at the edge, hold g unchanged. Other requests are ignored.
  - If req[g]=0 at the edge, go to TURN.
  - On leaving GRANT: ptr <= (g==0) ? N-1 : g-1.
- TURN: exactly one cycle with grant=0, busy=0.
  - If any req at the next edge, go directly to GRANT with the new selection (using the updated ptr). Otherwise go to IDLE.
  - A requester that re-asserts after release is eligible but is searched last.
- Timing outputs:
  - grant_id and busy are registered alongside grant; all three change on the same edge.
  - grant is never multi-hot.
  - grant never moves between requesters without an intervening zero cycle.
- Glitches: req changes between edges have no effect; only the value sampled at the edge matters.
- Reset mid-grant: all outputs clear immediately on reset falling. After reset rises, the first edge arbitrates from ptr=N-1.
- req bits at index >= N do not exist; grant_id takes only the values 0..N-1.

Optional Feature:
- Macro ARB_MAX_HOLD_EN.
- Defined:
  - hold_cnt clears on entering GRANT and increments each cycle spent in GRANT.
  - At the edge ending the HOLD_MAX-th granted cycle, if any other req bit (req & ~grant) is 1, go to TURN even though req[g]=1. The ptr update is the same as a normal release.
  - If no other request is pending, the grant continues and hold_cnt saturates at HOLD_MAX.
  - A normal release before HOLD_MAX behaves as in the base behaviour.
- Not defined: no hold_cnt register is built. A grant is held indefinitely while req[g]=1.

Test Plan:
- Reset: reset=0, req=1111, clocks running → grant=0000, grant_id=0, busy=0. Release reset → grant=1000, grant_id=3, busy=1 after the first rising edge.
- Rotation: req=1111, each granted requester drops its bit 2 cycles after its grant and re-raises it one cycle later → grant sequence 1000,0000,0100,0000,0010,0000,0001,0000,1000. Each grant lasts 2 cycles; each gap lasts 1 cycle.
- Pointer: after requester 1 releases (ptr=0), req=1011 at the TURN edge → next grant=0001 (not 1000), grant_id=0.
- Single requester: req=0001 for 5 cycles then 0000 → grant=0001 for 5 cycles, grant=0000 from the edge that samples req=0, then IDLE.
- Async reset mid-grant: grant=0100, reset driven 0 midway between edges → grant=0000, busy=0 with no clock edge. After release, req=0100 → grant=0100 one edge later.
- ARB_MAX_HOLD_EN, HOLD_MAX=8, req=1100 held constant → grant=1000 for 8 cycles, 0000 for 1 cycle, then 0100 for 8 cycles, repeating. With req=1000 only → grant=1000 held indefinitely.
